// File: rtl/bz_dl_pkg.sv
// Shared types and constants for the Battlezone HPS download router.
// Download indices, game-select codes and the router state encoding live here.
package bz_dl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ROM,
        ST_MOD,
        ST_DSW,
        ST_SKIP,
        ST_HOLD
    } dl_state_t;

    localparam logic [7:0] IDX_ROM = 8'd0;
    localparam logic [7:0] IDX_MOD = 8'd1;
    localparam logic [7:0] IDX_DSW = 8'd254;

    localparam logic [7:0] MOD_BATTLEZONE = 8'd0;
    localparam logic [7:0] MOD_BRADLEY    = 8'd1;
    localparam logic [7:0] MOD_REDBARON   = 8'd2;
    localparam logic [7:0] MOD_NONE       = 8'hFF;

    function automatic dl_state_t index_state(input logic [7:0] idx);
        case (idx)
            IDX_ROM: return ST_ROM;
            IDX_MOD: return ST_MOD;
            IDX_DSW: return ST_DSW;
            default: return ST_SKIP;
        endcase
    endfunction

endpackage

// File: rtl/bz_dl_router.sv
// Routes HPS downloads to ROM, game-select or DIP registers by ioctl_index,
// and stretches the core reset over the whole download plus a settle window.
module bz_dl_router #(
    parameter int         ROM_BYTES   = 65536,
    parameter int         HOLD_CYCLES = 64,
    parameter logic [7:0] DSW0_DEF    = 8'h00,
    parameter logic [7:0] DSW1_DEF    = 8'h00
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ioctl_download,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    input  logic [7:0]  ioctl_index,
    output logic [24:0] dl_addr,
    output logic [7:0]  dl_data,
    output logic        dl_wr,
    output logic [7:0]  mod,
    output logic [7:0]  dsw0,
    output logic [7:0]  dsw1,
    output logic        core_reset,
    output logic        rom_ok,
    output logic        rom_ovf
);
    import bz_dl_pkg::*;

    localparam int              HW        = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HW-1:0]   HOLD_LOAD = HW'(HOLD_CYCLES - 1);
    localparam logic [32:0]     ROM_LIMIT = 33'(ROM_BYTES);

    dl_state_t     state, state_next;
    logic [HW-1:0] hold_cnt, hold_next;
    logic          dl_prev;
    logic          dl_rise, dl_fall;
    logic [16:0]   byte_cnt, cnt_eff;
    logic          ovf_seen, ovf_eff;
    logic          in_range, rom_accept, rom_reject, entering_rom;

    assign dl_rise = ioctl_download & ~dl_prev;
    assign dl_fall = ~ioctl_download & dl_prev;

    assign in_range     = ({8'b0, ioctl_addr} < ROM_LIMIT);
    assign rom_accept   = (state == ST_ROM) & ioctl_wr & in_range;
    assign rom_reject   = (state == ST_ROM) & ioctl_wr & ~in_range;
    assign entering_rom = (state_next == ST_ROM) & (state != ST_ROM);

    // The byte landing in the falling-edge cycle still counts towards rom_ok.
    assign cnt_eff = (rom_accept && byte_cnt != '1) ? byte_cnt + 17'd1 : byte_cnt;
    assign ovf_eff = ovf_seen | rom_reject;

    // dl_prev resets high so a download still asserted across reset is not
    // mistaken for a fresh start.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            hold_cnt   <= '0;
            dl_prev    <= 1'b1;
            core_reset <= 1'b1;
        end else begin
            state      <= state_next;
            hold_cnt   <= hold_next;
            dl_prev    <= ioctl_download;
            core_reset <= (state_next != ST_IDLE);
        end
    end

    always_comb begin
        state_next = state;
        hold_next  = hold_cnt;
        unique case (state)
            ST_IDLE: begin
                if (dl_rise) state_next = index_state(ioctl_index);
            end
            ST_ROM, ST_MOD, ST_DSW, ST_SKIP: begin
                if (dl_fall) begin
                    state_next = ST_HOLD;
                    hold_next  = HOLD_LOAD;
                end
            end
            ST_HOLD: begin
                if (dl_rise) begin
                    state_next = index_state(ioctl_index);
                end else if (hold_cnt == '0) begin
                    state_next = ST_IDLE;
                end else begin
                    hold_next = hold_cnt - 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            dl_addr  <= '0;
            dl_data  <= '0;
            dl_wr    <= 1'b0;
            byte_cnt <= '0;
            ovf_seen <= 1'b0;
            rom_ok   <= 1'b0;
            rom_ovf  <= 1'b0;
        end else begin
            dl_wr <= rom_accept;
            if (rom_accept) begin
                dl_addr <= ioctl_addr;
                dl_data <= ioctl_dout;
            end
            if (entering_rom) begin
                byte_cnt <= '0;
                ovf_seen <= 1'b0;
                rom_ok   <= 1'b0;
                rom_ovf  <= 1'b0;
            end else if (state == ST_ROM) begin
                byte_cnt <= cnt_eff;
                ovf_seen <= ovf_eff;
                if (dl_fall) begin
                    rom_ok  <= (cnt_eff != '0) & ~ovf_eff;
                    rom_ovf <= ovf_eff;
                end
            end
        end
    end

    // Only the first eight DIP addresses are decoded; 2..7 are reserved banks.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            mod  <= MOD_NONE;
            dsw0 <= DSW0_DEF;
            dsw1 <= DSW1_DEF;
        end else begin
            if (state == ST_MOD && ioctl_wr) mod <= ioctl_dout;
            if (state == ST_DSW && ioctl_wr && ioctl_addr[24:3] == '0) begin
                if (ioctl_addr[2:0] == 3'd0) dsw0 <= ioctl_dout;
                if (ioctl_addr[2:0] == 3'd1) dsw1 <= ioctl_dout;
            end
        end
    end

endmodule

// File: tb/tb_bz_dl_router.sv
// Self-checking bench for bz_dl_router: directed scenarios plus random downloads,
// compared every cycle against a download-level behavioural model.
module tb_bz_dl_router;

    localparam int         HOLD = 64;
    localparam int         ROMB = 65536;
    localparam logic [7:0] D0   = 8'h5A;
    localparam logic [7:0] D1   = 8'hC3;

    logic        clk_sys = 1'b0;
    logic        reset = 1'b1;
    logic        ioctl_download = 1'b0;
    logic        ioctl_wr = 1'b0;
    logic [24:0] ioctl_addr = '0;
    logic [7:0]  ioctl_dout = '0;
    logic [7:0]  ioctl_index = '0;
    logic [24:0] dl_addr;
    logic [7:0]  dl_data;
    logic        dl_wr;
    logic [7:0]  mod, dsw0, dsw1;
    logic        core_reset, rom_ok, rom_ovf;

    int checks = 0;
    int errors = 0;
    int wr_pulses = 0;
    bit tb_done = 1'b0;

    always #5 clk_sys = ~clk_sys;

    bz_dl_router #(
        .ROM_BYTES(ROMB), .HOLD_CYCLES(HOLD), .DSW0_DEF(D0), .DSW1_DEF(D1)
    ) dut (
        .clk_sys(clk_sys), .reset(reset),
        .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
        .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_index(ioctl_index),
        .dl_addr(dl_addr), .dl_data(dl_data), .dl_wr(dl_wr),
        .mod(mod), .dsw0(dsw0), .dsw1(dsw1),
        .core_reset(core_reset), .rom_ok(rom_ok), .rom_ovf(rom_ovf)
    );

    // Download-level model: kind of the active download, bytes and overflow seen,
    // and the number of cycles elapsed since the download ended.
    bit          m_prev = 1'b1, m_active = 1'b0, m_rise, m_fall, m_ovf = 1'b0;
    int          m_kind = 0, m_since_fall = HOLD, m_bytes = 0;
    logic        e_dl_wr = 1'b0, e_core_reset = 1'b1, e_rom_ok = 1'b0, e_rom_ovf = 1'b0;
    logic [24:0] e_dl_addr = '0;
    logic [7:0]  e_dl_data = '0, e_mod = 8'hFF, e_dsw0 = D0, e_dsw1 = D1;

    function automatic int classify(input logic [7:0] idx);
        if (idx == 8'd0) return 1;
        if (idx == 8'd1) return 2;
        if (idx == 8'd254) return 3;
        return 4;
    endfunction

    always @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            m_prev = 1'b1; m_active = 1'b0; m_kind = 0; m_since_fall = HOLD;
            m_bytes = 0; m_ovf = 1'b0;
            e_dl_wr = 1'b0; e_dl_addr = '0; e_dl_data = '0;
            e_mod = 8'hFF; e_dsw0 = D0; e_dsw1 = D1;
            e_core_reset = 1'b1; e_rom_ok = 1'b0; e_rom_ovf = 1'b0;
        end else begin
            m_rise = ioctl_download && !m_prev;
            m_fall = !ioctl_download && m_prev;
            e_dl_wr = 1'b0;
            if (m_active) begin
                if (ioctl_wr) begin
                    if (m_kind == 1) begin
                        if (int'(ioctl_addr) < ROMB) begin
                            e_dl_wr = 1'b1; e_dl_addr = ioctl_addr; e_dl_data = ioctl_dout;
                            m_bytes++;
                        end else begin
                            m_ovf = 1'b1;
                        end
                    end else if (m_kind == 2) begin
                        e_mod = ioctl_dout;
                    end else if (m_kind == 3 && int'(ioctl_addr) < 8) begin
                        if (ioctl_addr == 25'd0) e_dsw0 = ioctl_dout;
                        else if (ioctl_addr == 25'd1) e_dsw1 = ioctl_dout;
                    end
                end
                if (m_fall) begin
                    m_active = 1'b0;
                    m_since_fall = 0;
                    if (m_kind == 1) begin
                        e_rom_ok = (m_bytes > 0) && !m_ovf;
                        e_rom_ovf = m_ovf;
                    end
                end
            end else begin
                if (m_since_fall < HOLD) m_since_fall++;
                if (m_rise) begin
                    m_active = 1'b1;
                    m_kind = classify(ioctl_index);
                    m_since_fall = HOLD;
                    if (m_kind == 1) begin
                        m_bytes = 0; m_ovf = 1'b0; e_rom_ok = 1'b0; e_rom_ovf = 1'b0;
                    end
                end
            end
            e_core_reset = m_active || (m_since_fall < HOLD);
            m_prev = ioctl_download;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk_sys) begin
        if (!tb_done) begin
            checkOutput("dl_wr", 32'(dl_wr), 32'(e_dl_wr));
            checkOutput("dl_addr", 32'(dl_addr), 32'(e_dl_addr));
            checkOutput("dl_data", 32'(dl_data), 32'(e_dl_data));
            checkOutput("mod", 32'(mod), 32'(e_mod));
            checkOutput("dsw0", 32'(dsw0), 32'(e_dsw0));
            checkOutput("dsw1", 32'(dsw1), 32'(e_dsw1));
            checkOutput("core_reset", 32'(core_reset), 32'(e_core_reset));
            checkOutput("rom_ok", 32'(rom_ok), 32'(e_rom_ok));
            checkOutput("rom_ovf", 32'(rom_ovf), 32'(e_rom_ovf));
            if (dl_wr) wr_pulses++;
        end
    end

    task automatic applyStimulus(input logic dl, input logic wr, input logic [24:0] a,
                                 input logic [7:0] d, input logic [7:0] idx);
        @(posedge clk_sys);
        #1;
        ioctl_download = dl; ioctl_wr = wr; ioctl_addr = a; ioctl_dout = d; ioctl_index = idx;
    endtask

    task automatic waitIdle(input string name);
        int n = 0;
        while (core_reset && n < 300) begin
            @(posedge clk_sys);
            #1;
            n++;
        end
        checkOutput(name, 32'(core_reset), 32'd0);
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int base, n;
        logic [7:0] idx, idx_drive, d;
        logic [24:0] a;
        logic wr;
        int len, gap;

        // Reset and idle
        repeat (3) @(posedge clk_sys);
        #1;
        checkOutput("rst_core_reset", 32'(core_reset), 32'd1);
        checkOutput("rst_mod", 32'(mod), 32'hFF);
        checkOutput("rst_dsw0", 32'(dsw0), 32'(D0));
        checkOutput("rst_dsw1", 32'(dsw1), 32'(D1));
        checkOutput("rst_dl_wr", 32'(dl_wr), 32'd0);
        reset = 1'b0;
        base = wr_pulses;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(0, 0, 0, 0, 0);
            checkOutput("idle_core_reset", 32'(core_reset), 32'd0);
        end
        checkOutput("idle_no_dl_wr", 32'(wr_pulses - base), 32'd0);

        // ROM download of four bytes and reset stretch length
        base = wr_pulses;
        applyStimulus(1, 0, 0, 0, 8'd0);
        for (int i = 0; i < 4; i++) applyStimulus(1, 1, 25'(i), 8'(8'hA0 + i), 8'd0);
        applyStimulus(1, 0, 0, 0, 8'd0);
        applyStimulus(0, 0, 0, 0, 8'd0);
        n = 0;
        while (core_reset && n < 200) begin
            @(posedge clk_sys);
            #1;
            n++;
        end
        checkOutput("hold_len", 32'(n), 32'd65);
        checkOutput("rom4_pulses", 32'(wr_pulses - base), 32'd4);
        checkOutput("rom4_addr", 32'(dl_addr), 32'd3);
        checkOutput("rom4_data", 32'(dl_data), 32'hA3);
        checkOutput("rom4_ok", 32'(rom_ok), 32'd1);
        checkOutput("rom4_ovf", 32'(rom_ovf), 32'd0);

        // ROM boundary
        base = wr_pulses;
        applyStimulus(1, 0, 0, 0, 8'd0);
        applyStimulus(1, 1, 25'h0FFFF, 8'hAA, 8'd0);
        applyStimulus(1, 1, 25'h10000, 8'hBB, 8'd0);
        applyStimulus(1, 0, 0, 0, 8'd0);
        applyStimulus(0, 0, 0, 0, 8'd0);
        waitIdle("bnd_idle");
        checkOutput("bnd_pulses", 32'(wr_pulses - base), 32'd1);
        checkOutput("bnd_addr", 32'(dl_addr), 32'h0FFFF);
        checkOutput("bnd_data", 32'(dl_data), 32'hAA);
        checkOutput("bnd_ok", 32'(rom_ok), 32'd0);
        checkOutput("bnd_ovf", 32'(rom_ovf), 32'd1);

        // DIP switches then game select
        applyStimulus(1, 0, 0, 0, 8'd254);
        applyStimulus(1, 1, 25'd0, 8'h12, 8'd254);
        applyStimulus(1, 1, 25'd1, 8'h34, 8'd254);
        applyStimulus(1, 1, 25'd5, 8'hFF, 8'd254);
        applyStimulus(1, 1, 25'd8, 8'h77, 8'd254);
        applyStimulus(0, 0, 0, 0, 8'd254);
        waitIdle("dsw_idle");
        checkOutput("dsw0_val", 32'(dsw0), 32'h12);
        checkOutput("dsw1_val", 32'(dsw1), 32'h34);
        applyStimulus(1, 0, 0, 0, 8'd1);
        applyStimulus(1, 1, 25'd0, 8'h02, 8'd1);
        applyStimulus(0, 0, 0, 0, 8'd1);
        waitIdle("mod_idle");
        checkOutput("mod_val", 32'(mod), 32'h02);
        checkOutput("mod_dsw0_kept", 32'(dsw0), 32'h12);
        checkOutput("mod_dsw1_kept", 32'(dsw1), 32'h34);

        // Index change mid-download, then restart inside the hold window
        base = wr_pulses;
        applyStimulus(1, 0, 0, 0, 8'd1);
        applyStimulus(1, 0, 0, 0, 8'd0);
        applyStimulus(1, 1, 25'd3, 8'h55, 8'd0);
        applyStimulus(0, 0, 0, 0, 8'd0);
        checkOutput("chg_mod", 32'(mod), 32'h55);
        checkOutput("chg_no_dl_wr", 32'(wr_pulses - base), 32'd0);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(0, 0, 0, 0, 8'd0);
            checkOutput("rehold_core_reset", 32'(core_reset), 32'd1);
        end
        applyStimulus(1, 0, 0, 0, 8'd7);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1, 1, 25'(i), 8'h99, 8'd7);
            checkOutput("rehold_core_reset", 32'(core_reset), 32'd1);
        end
        applyStimulus(0, 0, 0, 0, 8'd7);
        waitIdle("skip_idle");
        checkOutput("skip_mod_kept", 32'(mod), 32'h55);

        // Async reset during a ROM download
        applyStimulus(1, 0, 0, 0, 8'd0);
        applyStimulus(1, 1, 25'd0, 8'h11, 8'd0);
        applyStimulus(1, 1, 25'd1, 8'h22, 8'd0);
        @(posedge clk_sys);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("arst_core_reset", 32'(core_reset), 32'd1);
        checkOutput("arst_dl_wr", 32'(dl_wr), 32'd0);
        checkOutput("arst_mod", 32'(mod), 32'hFF);
        checkOutput("arst_dsw0", 32'(dsw0), 32'(D0));
        checkOutput("arst_dl_addr", 32'(dl_addr), 32'd0);
        repeat (2) @(posedge clk_sys);
        #1;
        reset = 1'b0;
        base = wr_pulses;
        for (int i = 0; i < 4; i++) applyStimulus(1, 1, 25'(i + 4), 8'h33, 8'd0);
        applyStimulus(1, 0, 0, 0, 8'd0);
        checkOutput("arst_ignored", 32'(wr_pulses - base), 32'd0);
        checkOutput("arst_core_low", 32'(core_reset), 32'd0);
        applyStimulus(0, 0, 0, 0, 8'd0);
        applyStimulus(1, 0, 0, 0, 8'd0);
        applyStimulus(1, 1, 25'd9, 8'h99, 8'd0);
        applyStimulus(1, 0, 0, 0, 8'd0);
        applyStimulus(0, 0, 0, 0, 8'd0);
        checkOutput("arst_resume_pulses", 32'(wr_pulses - base), 32'd1);
        checkOutput("arst_resume_addr", 32'(dl_addr), 32'd9);
        checkOutput("arst_resume_data", 32'(dl_data), 32'h99);
        waitIdle("arst_idle");

        // Random downloads
        for (int t = 0; t < 150; t++) begin
            case ($urandom % 5)
                0, 3:    idx = 8'd0;
                1:       idx = 8'd1;
                2:       idx = 8'd254;
                default: idx = 8'($urandom);
            endcase
            applyStimulus(1, 0, 0, 0, idx);
            len = int'($urandom_range(0, 12));
            for (int k = 0; k <= len; k++) begin
                case ($urandom % 3)
                    0:       a = 25'($urandom_range(0, 9));
                    1:       a = 25'($urandom_range(ROMB - 2, ROMB + 1));
                    default: a = 25'($urandom);
                endcase
                d = 8'($urandom);
                wr = ($urandom % 4) != 0;
                idx_drive = (($urandom % 6) == 0) ? 8'($urandom) : idx;
                applyStimulus((k == len) ? 1'b0 : 1'b1, wr, a, d, idx_drive);
            end
            gap = (($urandom % 3) == 0) ? int'($urandom_range(60, 70)) : int'($urandom_range(0, 20));
            for (int g = 0; g < gap; g++)
                applyStimulus(0, ($urandom % 5) == 0, 25'($urandom_range(0, 3)), 8'($urandom), idx);
        end
        applyStimulus(0, 0, 0, 0, 8'd0);
        waitIdle("rand_idle");
        @(negedge clk_sys);
        tb_done = 1'b1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
